sync_fifo_flags: RTL and testbench



---
 rtl/sync_fifo_flags.sv | 121 ++++++++++++
 tb/tb_sync_fifo_flags.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy count, threshold flags, sticky errors, FWFT option
module sync_fifo_flags #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2048,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write,
    input  logic             read,
    input  logic             err_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             fifo_full,
    output logic             fifo_not_full,
    output logic             fifo_empty,
    output logic             fifo_not_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;

    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CW-1:0]    w_count_nxt;

    // Acceptance uses the pre-edge flags, so a pop never frees room for a same-cycle push.
    assign w_wr_acc    = write & ~r_full;
    assign w_rd_acc    = read & ~r_empty;
    assign w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= (AF_LEVEL <= 0);
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == CW'(DEPTH));
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= CW'(AF_LEVEL));
            r_almost_empty <= (w_count_nxt <= CW'(AE_LEVEL));
            // A new error in the same cycle as err_clr keeps the flag set.
            r_overflow     <= (write & r_full) | (r_overflow & ~err_clr);
            r_underflow    <= (read & r_empty) | (r_underflow & ~err_clr);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out   = r_mem[r_rptr];
            assign data_valid = ~r_empty;
        end else begin : g_registered
            logic [WIDTH-1:0] r_data_out;
            logic             r_data_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else begin
                    r_data_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_data_out <= r_mem[r_rptr];
                    end
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

    assign count          = r_count;
    assign fifo_full      = r_full;
    assign fifo_not_full  = ~r_full;
    assign fifo_empty     = r_empty;
    assign fifo_not_empty = ~r_empty;
    assign almost_full    = r_almost_full;
    assign almost_empty   = r_almost_empty;
    assign overflow       = r_overflow;
    assign underflow      = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - randomized scoreboard bench for sync_fifo_flags in registered and FWFT modes
module tb_sync_fifo_flags;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 2;
    localparam int CW = $clog2(D + 1);

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         write;
    logic         read;
    logic         err_clr;

    logic [W-1:0]  dout0, dout1;
    logic          dv0, dv1;
    logic          full0, nfull0, empty0, nempty0, af0, ae0, ovf0, udf0;
    logic          full1, nfull1, empty1, nempty1, af1, ae1, ovf1, udf1;
    logic [CW-1:0] cnt0, cnt1;

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .write(write), .read(read), .err_clr(err_clr),
        .data_out(dout0), .data_valid(dv0), .fifo_full(full0), .fifo_not_full(nfull0),
        .fifo_empty(empty0), .fifo_not_empty(nempty0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .write(write), .read(read), .err_clr(err_clr),
        .data_out(dout1), .data_valid(dv1), .fifo_full(full1), .fifo_not_full(nfull1),
        .fifo_empty(empty1), .fifo_not_empty(nempty1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           cnt;
        bit           full;
        bit           empty;
        bit           af;
        bit           ae;
        bit           ovf;
        bit           udf;
        bit           dv0;
        logic [W-1:0] last0;
        logic [W-1:0] head;
    } exp_t;

    exp_t         sq[$];
    logic [W-1:0] q0[$];
    logic [W-1:0] mq[$];
    bit           m_ovf;
    bit           m_udf;
    logic [W-1:0] m_last0;
    int           checks;
    int           errors;
    exp_t         e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain queue of words; flags are pure functions of its size.
    task automatic step(input bit w, input bit r, input logic [W-1:0] d, input bit c, input bit rs);
        bit   was_full, was_empty, racc;
        exp_t x;
        write   = w;
        read    = r;
        data_in = d;
        err_clr = c;
        rst     = rs;
        racc    = 1'b0;
        if (rs) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_udf   = 1'b0;
            m_last0 = '0;
        end else begin
            was_full  = (mq.size() == D);
            was_empty = (mq.size() == 0);
            m_ovf = (w && was_full) || (m_ovf && !c);
            m_udf = (r && was_empty) || (m_udf && !c);
            if (r && !was_empty) begin
                racc    = 1'b1;
                m_last0 = mq.pop_front();
                q0.push_back(m_last0);
            end
            if (w && !was_full) mq.push_back(d);
        end
        x.cnt   = mq.size();
        x.full  = (mq.size() == D);
        x.empty = (mq.size() == 0);
        x.af    = (mq.size() >= AF);
        x.ae    = (mq.size() <= AE);
        x.ovf   = m_ovf;
        x.udf   = m_udf;
        x.dv0   = racc;
        x.last0 = m_last0;
        x.head  = (mq.size() > 0) ? mq[0] : '0;
        sq.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("count0", int'(cnt0), e.cnt);
            chk("count1", int'(cnt1), e.cnt);
            chk("full0", full0, e.full);
            chk("nfull0", nfull0, !e.full);
            chk("empty0", empty0, e.empty);
            chk("nempty0", nempty0, !e.empty);
            chk("full1", full1, e.full);
            chk("empty1", empty1, e.empty);
            chk("nempty1", nempty1, !e.empty);
            chk("af0", af0, e.af);
            chk("ae0", ae0, e.ae);
            chk("af1", af1, e.af);
            chk("ae1", ae1, e.ae);
            chk("ovf0", ovf0, e.ovf);
            chk("udf0", udf0, e.udf);
            chk("ovf1", ovf1, e.ovf);
            chk("udf1", udf1, e.udf);
            chk("dv0", dv0, e.dv0);
            chk("dout0_hold", int'(dout0), int'(e.last0));
            chk("dv1", dv1, !e.empty);
            if (!e.empty) chk("dout1_head", int'(dout1), int'(e.head));
        end
        if (dv0) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dv0_unexpected: got valid with data %0h expected no pop at %0t", dout0, $time);
            end else begin
                chk("dout0_pop", int'(dout0), int'(q0.pop_front()));
            end
        end
    end

    initial begin
        int wp, rp;
        checks = 0;
        errors = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_last0 = '0;

        step(0, 0, '0, 0, 1);
        step(0, 0, '0, 0, 0);
        for (int i = 1; i <= 8; i++) step(1, 0, W'(i), 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
        step(0, 0, '0, 0, 0);

        for (int i = 0; i < 8; i++) step(1, 0, W'($urandom), 0, 0);
        step(1, 0, 16'hDEAD, 0, 0);
        step(1, 1, 16'hDEAD, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
        step(0, 0, '0, 1, 0);

        step(1, 1, 16'h0055, 0, 0);
        step(0, 1, '0, 0, 0);
        step(0, 1, '0, 1, 0);
        step(0, 0, '0, 1, 0);

        for (int i = 0; i < 3; i++) step(1, 0, W'(16'h100 + i), 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, W'(16'h103 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, '0, 0, 0);

        for (int i = 0; i < 5; i++) step(1, 0, W'(16'h200 + i), 0, 0);
        step(1, 1, 16'h0BAD, 1, 1);
        step(1, 0, 16'h00A5, 0, 0);
        step(0, 1, '0, 0, 0);
        step(0, 0, '0, 0, 0);

        step(1, 0, 16'h0011, 0, 0);
        step(0, 0, '0, 0, 0);
        step(1, 1, 16'h0022, 0, 0);
        step(0, 0, '0, 0, 0);
        step(0, 1, '0, 0, 0);
        step(0, 0, '0, 0, 0);

        wp = 50;
        rp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                wp = $urandom_range(10, 95);
                rp = $urandom_range(10, 95);
            end
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, W'($urandom),
                 $urandom_range(0, 99) < 3, $urandom_range(0, 599) == 0);
        end

        step(0, 0, '0, 0, 0);
        step(0, 0, '0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drain", sq.size(), 0);
        chk("pop_queue_drain", q0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
